// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC and fetches over a req/ack handshake.
// It holds each fetched instruction stable for decode until it retires.
// Optional feature macro FETCH_PERF_EN adds the retire_cnt and stall_cnt
// performance counters.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        pc_src,
  input  logic [31:0]       rs_data,
  input  logic              alu_zero,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] retire_cnt,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC} state_t;

  localparam logic [2:0] SRC_NEXT = 3'd0;
  localparam logic [2:0] SRC_JUMP = 3'd1;
  localparam logic [2:0] SRC_JR   = 3'd2;
  localparam logic [2:0] SRC_BEQ  = 3'd3;
  localparam logic [2:0] SRC_BNE  = 3'd4;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic        req_q;
  logic [31:0] pc_plus4_w;
  logic [31:0] br_target_w;
  logic [31:0] next_pc_d;
  logic        retire_w;

  assign pc_plus4_w  = pc_q + 32'd4;
  // Branch offset is the sign-extended word displacement, relative to pc+4.
  assign br_target_w = pc_plus4_w + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign retire_w    = (state_q == S_EXEC) && en;

  // Next-PC selection; only consumed on the retiring EXEC cycle.
  always_comb begin
    next_pc_d = pc_plus4_w;
    case (pc_src)
      SRC_NEXT: next_pc_d = pc_plus4_w;
      SRC_JUMP: next_pc_d = {pc_plus4_w[31:28], inst_q[25:0], 2'b00};
      SRC_JR:   next_pc_d = rs_data;
      SRC_BEQ:  next_pc_d = alu_zero  ? br_target_w : pc_plus4_w;
      SRC_BNE:  next_pc_d = !alu_zero ? br_target_w : pc_plus4_w;
      default:  next_pc_d = pc_plus4_w;
    endcase
  end

  // Fetch FSM: BOOT -> FETCH (wait for ack) -> EXEC (wait for en) -> FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          // Ack is taken regardless of en: the memory transaction never aborts.
          if (imem_ack) begin
            inst_q       <= imem_rdata;
            inst_valid_q <= 1'b1;
            req_q        <= 1'b0;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (en) begin
            pc_q         <= next_pc_d;
            inst_valid_q <= 1'b0;
            req_q        <= 1'b1;
            state_q      <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_w;

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0] retire_cnt_q;
  logic [PERF_W-1:0] stall_cnt_q;
  logic              stall_w;

  assign stall_w = ((state_q == S_FETCH) && !imem_ack) ||
                   ((state_q == S_EXEC) && !en);

  // Free-running wrap-around counters of retired instructions and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (retire_w) retire_cnt_q <= retire_cnt_q + 1'b1;
      if (stall_w)  stall_cnt_q  <= stall_cnt_q + 1'b1;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  // Retirement is only observable through the FSM when counters are absent.
  logic unused_w;
  assign unused_w = retire_w;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then a randomized run, checked
// against a transaction-level reference model of the fetch/retire protocol.
module tb_inst_fetch;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          PW  = 32;

  logic        clk, rst_n, en, alu_zero, imem_ack;
  logic [2:0]  pc_src;
  logic [31:0] rs_data, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, pc, pc_plus4;
`ifdef FETCH_PERF_EN
  logic [PW-1:0] retire_cnt, stall_cnt;
`endif

  inst_fetch #(.RESET_PC(RPC), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_src(pc_src), .rs_data(rs_data),
    .alu_zero(alu_zero), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .inst(inst),
    .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4)
`ifdef FETCH_PERF_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Reference model state: where the instruction is in its life cycle.
  bit          m_boot, m_req, m_valid;
  logic [31:0] m_pc, m_inst;
  int          m_retired, m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [2:0] src, input logic [31:0] rs,
                                           input logic z);
    logic [31:0] p4, off;
    p4  = p + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]} * 32'd4;
    case (src)
      3'd1:    return {p4[31:28], ins[25:0], 2'b00};
      3'd2:    return rs;
      3'd3:    return z ? p4 + off : p4;
      3'd4:    return !z ? p4 + off : p4;
      default: return p4;
    endcase
  endfunction

  task automatic model_reset();
    m_boot = 1; m_req = 0; m_valid = 0; m_pc = RPC; m_inst = 32'h0;
    m_retired = 0; m_stalls = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".req"},   {31'h0, imem_req},   {31'h0, m_req});
    chk({tag, ".addr"},  imem_addr,           m_pc);
    chk({tag, ".inst"},  inst,                m_inst);
    chk({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, m_valid});
    chk({tag, ".pc"},    pc,                  m_pc);
    chk({tag, ".pc4"},   pc_plus4,            m_pc + 32'd4);
`ifdef FETCH_PERF_EN
    chk({tag, ".retire_cnt"}, retire_cnt, m_retired);
    chk({tag, ".stall_cnt"},  stall_cnt,  m_stalls);
`endif
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, compare mid-cycle.
  task automatic step(input string tag, input logic e, input logic a, input logic [31:0] rd,
                      input logic [2:0] src, input logic [31:0] rs, input logic z);
    en = e; imem_ack = a; imem_rdata = rd; pc_src = src; rs_data = rs; alu_zero = z;
    @(posedge clk);
    if (m_boot) begin
      m_boot = 0; m_req = 1;
    end else if (m_req) begin
      if (a) begin m_inst = rd; m_valid = 1; m_req = 0; end
      else m_stalls++;
    end else if (m_valid) begin
      if (e) begin
        m_pc = ref_next(m_pc, m_inst, src, rs, z);
        m_valid = 0; m_req = 1; m_retired++;
      end else m_stalls++;
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) step("wait", 1'b1, 1'b0, 32'hDEAD_BEEF, 3'd0, 0, 1'b0);
    step("ack", 1'b0, 1'b1, word, 3'd0, 0, 1'b0);
  endtask

  task automatic retire(input logic [2:0] src, input logic [31:0] rs, input logic z);
    step("retire", 1'b1, 1'b0, 32'h0, src, rs, z);
  endtask

  logic [31:0] addr0, pc_hold, inst_hold;
  int w;
  int st0;

  initial begin
    rst_n = 1'b0; en = 0; imem_ack = 0; imem_rdata = 0; pc_src = 0; rs_data = 0; alu_zero = 0;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    chk("reset.inst_nop", inst, 32'h0);

    // BOOT, one wait cycle, then a NOP stream with sequential addresses.
    rst_n = 1'b1;
    step("boot", 1'b1, 1'b0, 32'h0, 3'd0, 0, 1'b0);
    chk("boot.addr0", imem_addr, 32'h0);
    fetch(32'h0, 1);
    chk("nop.valid", {31'h0, inst_valid}, 32'h1);
    retire(3'd0, 0, 1'b0);
    chk("nop.addr4", imem_addr, 32'h4);
    chk("nop.valid_pulse", {31'h0, inst_valid}, 32'h0);
    fetch(32'h0, 0);
    retire(3'd0, 0, 1'b0);
    chk("nop.addr8", imem_addr, 32'h8);

    // BEQ taken / not taken from pc=0x100.
    fetch(32'h0, 0); retire(3'd2, 32'h100, 1'b0);
    fetch(32'h1000_FFFE, 0); retire(3'd3, 0, 1'b1);
    chk("beq.taken", pc, 32'h0000_00FC);
    fetch(32'h0, 0); retire(3'd2, 32'h100, 1'b0);
    fetch(32'h1000_FFFE, 0); retire(3'd3, 0, 1'b0);
    chk("beq.not_taken", pc, 32'h0000_0104);

    // JUMP and JR.
    fetch(32'h0, 0); retire(3'd2, 32'h0040_0010, 1'b0);
    fetch(32'h0800_0040, 0); retire(3'd1, 0, 1'b0);
    chk("jump", pc, 32'h0000_0100);
    fetch(32'h0, 0); retire(3'd2, 32'h1234_5678, 1'b0);
    chk("jr", pc, 32'h1234_5678);

    // PC wrap on NEXT.
    fetch(32'h0, 0); retire(3'd2, 32'hFFFF_FFFC, 1'b0);
    fetch(32'h0, 0); retire(3'd0, 0, 1'b0);
    chk("wrap", pc, 32'h0);

    // Delayed ack: request and address held stable.
`ifdef FETCH_PERF_EN
    st0 = int'(stall_cnt);
`endif
    addr0 = imem_addr;
    for (int i = 0; i < 3; i++) begin
      step("delay", 1'b0, 1'b0, 32'h0, 3'd0, 0, 1'b0);
      chk("delay.req", {31'h0, imem_req}, 32'h1);
      chk("delay.addr", imem_addr, addr0);
    end
    step("delay.ack", 1'b0, 1'b1, 32'h2000_0001, 3'd0, 0, 1'b0);
`ifdef FETCH_PERF_EN
    chk("delay.stall3", stall_cnt - st0, 32'd3);
`endif

    // en=0 hold in EXEC with spurious acks; then exactly one retirement.
    pc_hold = pc; inst_hold = inst;
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b0, 1'b1, 32'hFFFF_0000, 3'd2, 32'h5555_5550, 1'b0);
      chk("hold.pc", pc, pc_hold);
      chk("hold.inst", inst, inst_hold);
      chk("hold.valid", {31'h0, inst_valid}, 32'h1);
    end
    retire(3'd0, 0, 1'b0);
    chk("hold.retire_once", pc, pc_hold + 32'd4);
    chk("hold.refetch", {31'h0, imem_req}, 32'h1);

    // Reset mid-FETCH with a late ack.
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.req", {31'h0, imem_req}, 32'h0);
    chk("rst.pc", pc, RPC);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    compare_all("rst.hold");
    rst_n = 1'b1;
    step("rst.boot", 1'b1, 1'b1, 32'hBAD0_BAD0, 3'd0, 0, 1'b0);
    chk("rst.late_ack", {31'h0, inst_valid}, 32'h0);
    chk("rst.refetch_addr", imem_addr, RPC);
    fetch(32'h0, 0);

    // Randomized run with random ack latency, enables and next-PC selects.
    w = $urandom_range(0, 3);
    for (int i = 0; i < 400; i++) begin
      logic a, e, z;
      logic [2:0] s;
      logic [31:0] rd, rs;
      e  = ($urandom % 3) != 0;
      s  = 3'($urandom % 8);
      z  = 1'($urandom);
      rs = $urandom;
      rd = $urandom;
      if (m_req) begin
        if (w == 0) begin a = 1'b1; w = $urandom_range(0, 3); end
        else begin a = 1'b0; w--; end
      end else begin
        a = ($urandom % 4) == 0;
      end
      step("rand", e, a, rd, s, rs, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
